vram_write_bridge: RTL and testbench

- Sits between the cpu master port (`mem_en`/`mem_we`/`mem_addr`/`mem_din`/`mem_dout`) and the PPU video memories.
- Decodes each CPU address into a VRAM region and queues writes in a FIFO.
- Drains the FIFO to the PPU one word per granted cycle, so CPU init bursts never collide with PPU fetches.
- Services CPU reads in order behind any pending writes.

---
 rtl/vram_write_bridge_if.sv | 34 +++
 rtl/vram_write_bridge.sv | 130 +++++++++++++
 tb/tb_vram_write_bridge.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_write_bridge_if.sv
// CPU-side and PPU-side buses of the VRAM write bridge.
// The slave modport is the bridge's view; the master modport is the CPU/PPU environment's view.
interface vram_write_bridge_if #(
    parameter int OFS_W = 20
);
    logic             cpu_en;
    logic             cpu_we;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_din;
    logic [31:0]      cpu_dout;
    logic             cpu_rvalid;
    logic             cpu_stall;
    logic             vblank;
    logic             vram_en;
    logic             vram_we;
    logic [1:0]       vram_sel;
    logic [OFS_W-1:0] vram_addr;
    logic [31:0]      vram_din;
    logic [31:0]      vram_dout;
    logic             vram_gnt;
    logic             err_unmapped;

    modport slave (
        input  cpu_en, cpu_we, cpu_addr, cpu_din, vblank, vram_dout, vram_gnt,
        output cpu_dout, cpu_rvalid, cpu_stall, vram_en, vram_we, vram_sel,
               vram_addr, vram_din, err_unmapped
    );

    modport master (
        output cpu_en, cpu_we, cpu_addr, cpu_din, vblank, vram_dout, vram_gnt,
        input  cpu_dout, cpu_rvalid, cpu_stall, vram_en, vram_we, vram_sel,
               vram_addr, vram_din, err_unmapped
    );
endinterface

// File: rtl/vram_write_bridge.sv
// Queues CPU writes to PPU video memories and drains them one word per grant; reads wait behind writes.
// Optional VRAM_VBLANK_GATE_EN: PPU requests are only raised while vblank=1.
module vram_write_bridge #(
    parameter int FIFO_DEPTH = 16,
    parameter int OFS_W      = 20
) (
    input logic               clk,
    input logic               rst_n,
    vram_write_bridge_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, RD_WAIT, RD_DATA} state_t;

    typedef struct packed {
        logic [1:0]       sel;
        logic [OFS_W-1:0] ofs;
        logic [31:0]      data;
    } wr_ent_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       rd_sel_q, rd_sel_d;
    logic [OFS_W-1:0] rd_ofs_q, rd_ofs_d;
    logic             err_q, err_d;
    logic             unm_rd_q, unm_rd_d;
    wr_ent_t          mem_q [FIFO_DEPTH];

    logic    full, empty, stall, mapped, accept;
    logic    push, pop, rd_acc, unm;
    logic    gate, wr_req, rd_req, rd_gnt;
    wr_ent_t head, new_ent;

`ifdef VRAM_VBLANK_GATE_EN
    assign gate = bus.vblank;
`else
    logic unused_vblank;
    assign unused_vblank = bus.vblank;
    assign gate          = 1'b1;
`endif

    // Stall depends only on flops so the CPU never sees a combinational path from its own request.
    assign full   = (cnt_q == CW'(FIFO_DEPTH));
    assign empty  = (cnt_q == '0);
    assign stall  = full | (state_q == RD_WAIT) | (state_q == RD_DATA);
    assign mapped = (bus.cpu_addr[31:22] == 10'h018);
    assign accept = bus.cpu_en & ~stall;
    assign push   = accept & bus.cpu_we & mapped;
    assign rd_acc = accept & ~bus.cpu_we & mapped;
    assign unm    = accept & ~mapped;

    assign head    = mem_q[rd_ptr_q];
    assign new_ent = '{sel: bus.cpu_addr[21:20], ofs: bus.cpu_addr[OFS_W-1:0], data: bus.cpu_din};

    // Queued writes always go first; the held read is only presented once the queue is empty.
    assign wr_req = ~empty;
    assign rd_req = (state_q == RD_WAIT) & empty;
    assign pop    = wr_req & gate & bus.vram_gnt;
    assign rd_gnt = rd_req & gate & bus.vram_gnt;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rd_sel_d = rd_sel_q;
        rd_ofs_d = rd_ofs_q;
        err_d    = unm;
        unm_rd_d = unm & ~bus.cpu_we;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (rd_acc) begin
            rd_sel_d = bus.cpu_addr[21:20];
            rd_ofs_d = bus.cpu_addr[OFS_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DRAIN: begin
                if (rd_acc)              state_d = RD_WAIT;
                else if (cnt_d != '0)    state_d = DRAIN;
                else                     state_d = IDLE;
            end
            RD_WAIT: if (rd_gnt) state_d = RD_DATA;
            RD_DATA: state_d = (cnt_d != '0) ? DRAIN : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rd_sel_q <= '0;
            rd_ofs_q <= '0;
            err_q    <= 1'b0;
            unm_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rd_sel_q <= rd_sel_d;
            rd_ofs_q <= rd_ofs_d;
            err_q    <= err_d;
            unm_rd_q <= unm_rd_d;
        end
    end

    // Queue storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= new_ent;
    end

    assign bus.cpu_stall    = stall;
    assign bus.err_unmapped = err_q;
    assign bus.cpu_rvalid   = (state_q == RD_DATA) | unm_rd_q;
    assign bus.cpu_dout     = (state_q == RD_DATA) ? bus.vram_dout : 32'h0;

    assign bus.vram_en   = (wr_req | rd_req) & gate;
    assign bus.vram_we   = wr_req & gate;
    assign bus.vram_sel  = !bus.vram_en ? 2'b00 : (wr_req ? head.sel : rd_sel_q);
    assign bus.vram_addr = !bus.vram_en ? '0 : (wr_req ? head.ofs : rd_ofs_q);
    assign bus.vram_din  = bus.vram_we ? head.data : 32'h0;
endmodule

// File: tb/tb_vram_write_bridge.sv
// Bench for vram_write_bridge: vector table plus hand sequences, PPU-side scoreboard and memory model.
module tb_vram_write_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vram_write_bridge_if #(.OFS_W(20)) bus();

    vram_write_bridge #(.FIFO_DEPTH(16), .OFS_W(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [19:0] ofs;
        logic [31:0] data;
    } wexp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  sel;
        bit          mapped;
    } vec_t;

    wexp_t       wq[$];
    logic [31:0] rq[$];
    logic [31:0] shadow [logic [21:0]];
    logic [31:0] vmodel [logic [21:0]];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_err = 0;
    int          got_err = 0;
    logic        gnt_cfg = 1'b0;
    logic        rnd_en  = 1'b0;
    logic        rnd_bit = 1'b0;
    logic [31:0] vdout   = '0;
    vec_t        vecs [11];

    assign bus.vram_gnt  = rnd_en ? rnd_bit : gnt_cfg;
    assign bus.vram_dout = vdout;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_req(input bit we, input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] sel, input bit mapped);
        logic [21:0] key;
        key = {sel, addr[19:0]};
        if (!mapped) begin
            exp_err++;
            if (!we) rq.push_back(32'h0);
        end else if (we) begin
            wq.push_back('{sel: sel, ofs: addr[19:0], data: data});
            shadow[key] = data;
        end else begin
            rq.push_back(shadow.exists(key) ? shadow[key] : 32'h0);
        end
    endtask

    // Starts and ends at posedge+1; holds the request until the bridge stops stalling.
    task automatic cpu_req(input bit we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] sel, input bit mapped);
        int n = 0;
        bus.cpu_en = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_din = data;
        @(negedge clk);
        while (bus.cpu_stall && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 64'(n < 300), 64'd1);
        if (n < 300) expect_req(we, addr, data, sel, mapped);
        @(posedge clk); #1;
        bus.cpu_en = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((wq.size() != 0 || rq.size() != 0 || bus.cpu_stall || bus.vram_en) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 64'(n < 600), 64'd1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic monitor();
        wexp_t       e;
        logic [21:0] key;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!bus.vram_en)
                    check("idle_outputs_zero", {11'h0, bus.vram_we, bus.vram_sel, bus.vram_addr, bus.vram_din}, 64'h0);
                if (bus.vram_en && bus.vram_gnt) begin
                    key = {bus.vram_sel, bus.vram_addr};
                    if (bus.vram_we) begin
                        if (wq.size() == 0) begin
                            check("unexpected_vram_write", 64'd1, 64'd0);
                        end else begin
                            e = wq.pop_front();
                            check("vram_write", {10'h0, bus.vram_sel, bus.vram_addr, bus.vram_din},
                                  {10'h0, e.sel, e.ofs, e.data});
                        end
                        vmodel[key] = bus.vram_din;
                    end else begin
                        vdout = vmodel.exists(key) ? vmodel[key] : 32'h0;
                    end
                end
                if (bus.cpu_rvalid) begin
                    if (rq.size() == 0) begin
                        check("unexpected_rvalid", 64'd1, 64'd0);
                    end else begin
                        r = rq.pop_front();
                        check("read_data", 64'(bus.cpu_dout), 64'(r));
                    end
                end
                if (bus.err_unmapped) got_err++;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0600_0010, 32'h1111_0001, 2'd0, 1'b1};
        vecs[1]  = '{1'b1, 32'h0610_0020, 32'h2222_0002, 2'd1, 1'b1};
        vecs[2]  = '{1'b1, 32'h0620_0030, 32'h3333_0003, 2'd2, 1'b1};
        vecs[3]  = '{1'b1, 32'h0630_0040, 32'h4444_0004, 2'd3, 1'b1};
        vecs[4]  = '{1'b1, 32'h063F_FFFF, 32'hDEAD_BEEF, 2'd3, 1'b1};
        vecs[5]  = '{1'b1, 32'h0700_0000, 32'h5555_0005, 2'd0, 1'b0};
        vecs[6]  = '{1'b1, 32'h05F0_0001, 32'h6666_0006, 2'd0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0610_0020, 32'h0,         2'd1, 1'b1};
        vecs[8]  = '{1'b0, 32'h063F_FFFF, 32'h0,         2'd3, 1'b1};
        vecs[9]  = '{1'b0, 32'h0640_0000, 32'h0,         2'd0, 1'b0};
        vecs[10] = '{1'b0, 32'h0600_0010, 32'h0,         2'd0, 1'b1};

        bus.cpu_en = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
`ifdef VRAM_VBLANK_GATE_EN
        bus.vblank = 1'b1;
`else
        bus.vblank = 1'b0;
`endif

        fork
            monitor();
            forever begin
                @(posedge clk); #1;
                if (rnd_en) rnd_bit = 1'($urandom_range(0, 1));
            end
            begin
                #2000000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_vram_en", 64'(bus.vram_en), 64'd0);
        check("rst_vram_bus", {bus.vram_we, bus.vram_sel, bus.vram_addr, bus.vram_din}, 64'h0);
        check("rst_cpu_out", {bus.cpu_rvalid, bus.cpu_stall, bus.err_unmapped, bus.cpu_dout}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        gnt_cfg = 1'b1;

        // Single write, one-cycle latency to the PPU port
        cpu_req(1'b1, 32'h0610_0005, 32'h0000_002A, 2'd1, 1'b1);
        @(negedge clk);
        check("single_en_we", {bus.vram_en, bus.vram_we}, 64'h3);
        check("single_sel", 64'(bus.vram_sel), 64'd1);
        check("single_addr", 64'(bus.vram_addr), 64'd5);
        check("single_din", 64'(bus.vram_din), 64'h2A);
        @(posedge clk); #1;
        wait_drain();
        check("single_empty", {bus.vram_en, bus.cpu_stall}, 64'h0);

        // Vector table, always-granted then random grants
        for (int i = 0; i < 11; i++)
            cpu_req(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel, vecs[i].mapped);
        wait_drain();
        rnd_en = 1'b1;
        for (int i = 0; i < 11; i++)
            cpu_req(vecs[i].we, vecs[i].addr, vecs[i].data ^ 32'h00A5_5A00, vecs[i].sel, vecs[i].mapped);
        wait_drain();
        rnd_en = 1'b0;

        // Full FIFO: 16 accepted, 17th stalls until the first pop has landed
        gnt_cfg = 1'b0;
        for (int i = 0; i < 16; i++)
            cpu_req(1'b1, 32'h0620_0100 + 32'(i), 32'hF000_0000 + 32'(i), 2'd2, 1'b1);
        bus.cpu_en = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0620_0110; bus.cpu_din = 32'hF000_0010;
        @(negedge clk);
        check("full_stall", 64'(bus.cpu_stall), 64'd1);
        check("full_head_held", {bus.vram_en, bus.vram_addr}, {43'h0, 1'b1, 20'h00100});
        @(posedge clk); #1;
        @(negedge clk);
        check("full_stall_hold", 64'(bus.cpu_stall), 64'd1);
        @(posedge clk); #1;
        gnt_cfg = 1'b1;
        @(negedge clk);
        check("pop_same_cycle_still_stalled", 64'(bus.cpu_stall), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_drops_after_pop", 64'(bus.cpu_stall), 64'd0);
        expect_req(1'b1, 32'h0620_0110, 32'hF000_0010, 2'd2, 1'b1);
        @(posedge clk); #1;
        bus.cpu_en = 1'b0;
        wait_drain();

        // Read ordering behind a queued write
        cpu_req(1'b1, 32'h0630_0003, 32'hFFFF_0000, 2'd3, 1'b1);
        cpu_req(1'b0, 32'h0630_0003, 32'h0, 2'd3, 1'b1);
        wait_drain();

        // Unmapped write: single error pulse, no PPU request
        cpu_req(1'b1, 32'h0700_0000, 32'h1234_5678, 2'd0, 1'b0);
        @(negedge clk);
        check("unmapped_err_pulse", {bus.err_unmapped, bus.vram_en, bus.cpu_stall}, 64'h4);
        @(posedge clk); #1;
        @(negedge clk);
        check("unmapped_err_once", 64'(bus.err_unmapped), 64'd0);
        @(posedge clk); #1;

        // Reset mid-drain with 5 entries queued
        gnt_cfg = 1'b0;
        for (int i = 0; i < 5; i++)
            cpu_req(1'b1, 32'h0600_0200 + 32'(i), 32'hCAFE_0000 + 32'(i), 2'd0, 1'b1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_vram_en", 64'(bus.vram_en), 64'd0);
        check("rst_async_stall", 64'(bus.cpu_stall), 64'd0);
        wq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        gnt_cfg = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {bus.vram_en, bus.cpu_stall, bus.cpu_rvalid}, 64'h0);
        @(posedge clk); #1;
        cpu_req(1'b1, 32'h0600_0400, 32'h0BAD_F00D, 2'd0, 1'b1);
        wait_drain();

`ifdef VRAM_VBLANK_GATE_EN
        // Gated: request waits for vblank even with grant high
        bus.vblank = 1'b0;
        cpu_req(1'b1, 32'h0610_0300, 32'h7777_0007, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gated_no_en", 64'(bus.vram_en), 64'd0);
            @(posedge clk); #1;
        end
        bus.vblank = 1'b1;
        @(negedge clk);
        check("vblank_issue", {bus.vram_en, bus.vram_we, bus.vram_addr}, {42'h0, 2'b11, 20'h00300});
        @(posedge clk); #1;
        wait_drain();
`else
        // Ungated: vblank low does not hold back the drain
        cpu_req(1'b1, 32'h0610_0300, 32'h7777_0007, 2'd1, 1'b1);
        @(negedge clk);
        check("ungated_en", 64'(bus.vram_en), 64'd1);
        @(posedge clk); #1;
        wait_drain();
`endif

        check("writes_all_seen", 64'(wq.size()), 64'd0);
        check("reads_all_seen", 64'(rq.size()), 64'd0);
        check("err_pulse_count", 64'(got_err), 64'(exp_err));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
